// File: rtl/clock_divider_prog.sv
// clock_divider_prog
//   Run-time programmable clock divider for the CPU clock, with run, stop and
//   single-step modes. All logic runs on clk_in. clk_out is registered and has
//   a 50% duty cycle; tick is a one-cycle strobe in the clk_in domain that is
//   high in the same cycle clk_out rises.
// Ports
//   clk_in    system clock
//   reset_n   synchronous active-low reset
//   mode      0 STOP, 1 RUN, 2 STEP, 3 treated as STOP
//   step_req  one-cycle pulse, requests one clk_out period (STEP mode, parked)
//   div_half  new half-period in clk_in cycles (0 is stored as 1)
//   div_load  one-cycle pulse capturing div_half
//   clk_out   divided clock
//   tick      one-cycle pulse on each clk_out rising edge
//   busy      high while a single-step period is running
//   cur_half  half-period currently in use
//
// state  | meaning
// S_PARK | clk_out held low, counter cleared, waiting for RUN or a step request
// S_RUN  | free-running; leaves once a low phase can be entered cleanly
// S_STEP | one full period in progress (busy), always runs to completion
module clock_divider_prog #(
  parameter int unsigned CNT_W        = 25,
  parameter int unsigned DEFAULT_HALF = 2500000
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic [1:0]       mode,
  input  logic             step_req,
  input  logic [CNT_W-1:0] div_half,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] cur_half
);

  typedef enum logic [1:0] {
    S_PARK = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] DEF_HALF  = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [1:0]       MODE_RUN  = 2'd1;
  localparam logic [1:0]       MODE_STEP = 2'd2;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  logic [CNT_W-1:0] load_val;
  logic             term;

  // A zero half-period would never reach terminal count, so it becomes 1.
  assign load_val = (div_half == '0) ? ONE : div_half;
  assign term     = (cnt_q == (cur_q - ONE));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    clk_d      = clk_q;
    tick_d     = 1'b0;

    case (state_q)
      S_PARK: begin
        cnt_d = '0;
        clk_d = 1'b0;
        // Nothing is counting, so a new divisor can take effect at once and
        // is already in place for a period starting on this same edge.
        if (div_load) begin
          cur_d      = load_val;
          pend_d     = load_val;
          pend_vld_d = 1'b0;
        end else if (pend_vld_q) begin
          cur_d      = pend_q;
          pend_vld_d = 1'b0;
        end
        if (mode == MODE_RUN) begin
          state_d = S_RUN;
        end else if ((mode == MODE_STEP) && step_req) begin
          state_d = S_STEP;
        end
      end

      default: begin
        if ((state_q == S_RUN) && (mode != MODE_RUN) && !clk_q) begin
          // Stopping during a low half: park now rather than finish it.
          state_d = S_PARK;
          cnt_d   = '0;
          if (div_load) begin
            pend_d     = load_val;
            pend_vld_d = 1'b1;
          end
        end else if (term) begin
          cnt_d  = '0;
          clk_d  = !clk_q;
          tick_d = !clk_q;
          // Divisor changes only land on a half boundary.
          if (div_load) begin
            cur_d  = load_val;
            pend_d = load_val;
          end else if (pend_vld_q) begin
            cur_d = pend_q;
          end
          pend_vld_d = 1'b0;
          // A falling edge closes a period, for both run and step.
          if (clk_q) begin
            state_d = (mode == MODE_RUN) ? S_RUN : S_PARK;
          end
        end else begin
          cnt_d = cnt_q + ONE;
          if (div_load) begin
            pend_d     = load_val;
            pend_vld_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state_q    <= S_PARK;
      cnt_q      <= '0;
      cur_q      <= DEF_HALF;
      pend_q     <= DEF_HALF;
      pend_vld_q <= 1'b0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
    end
  end

  assign clk_out  = clk_q;
  assign tick     = tick_q;
  assign busy     = (state_q == S_STEP);
  assign cur_half = cur_q;

endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
Run-time programmable clock divider with run, stop and single-step modes, used to drive the on-board CPU clock. It generalises the fixed-divisor toggle divider in three ways: a parametrised counter width, a divisor that can be reloaded without glitches, and a glitch-free stop/step control for debugging. It also emits a one-cycle `tick` strobe in the `clk_in` domain so logic can act on each slow rising edge without using `clk_out` as a clock.

Parameters:
CNT_W, 25, width of the half-period counter and of the divisor input.
DEFAULT_HALF, 2500000, half-period in `clk_in` cycles after reset (10 Hz at 50 MHz).

Ports:
clk_in  input  1  system clock; all logic on its rising edge.
reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of `clk_in`.
mode  input  2  0 = STOP, 1 = RUN, 2 = STEP, 3 = reserved (treated as STOP).
step_req  input  1  one-cycle pulse requesting a single `clk_out` period; must already be debounced.
div_half  input  CNT_W  new half-period value in `clk_in` cycles.
div_load  input  1  one-cycle pulse; captures `div_half`.
clk_out  output  1  divided clock, registered.
tick  output  1  one-cycle pulse, high in the same cycle `clk_out` goes 0->1.
busy  output  1  high while a single-step period is in progress.
cur_half  output  CNT_W  half-period currently in use.

Behaviour:
- Reset (`reset_n` = 0 at a `clk_in` edge): `clk_out`=0, `tick`=0, `busy`=0, counter=0, `cur_half`=DEFAULT_HALF, pending register=DEFAULT_HALF, pending-valid=0. Reset overrides all other inputs and aborts any period or step in progress.
- Divisor clamp: a `div_half` value of 0 is stored as 1. The terminal count is `cur_half`-1.
- Half-period: while counting, the counter increments by 1 per cycle. At the terminal count, in one cycle: counter<=0, `clk_out` toggles, and the next half uses the updated `cur_half` (see divisor reload).
- Period: full period = 2*`cur_half` cycles; duty is exactly 50%.
- `tick`: registered. Set to 1 in the same cycle `clk_out` becomes 1, for exactly one cycle.
- Divisor reload: `div_load` writes the pending register and sets pending-valid.
  - When parked, the value is copied to `cur_half` on the next edge.
  - When not parked, the copy happens only at a terminal-count cycle. Pending-valid then clears.
  - If `div_load` coincides with a terminal count, the incoming `div_half` is applied directly.
  - A half-period in progress is never shortened or extended.
- Parked state: `clk_out`=0, counter=0, `busy`=0.
- RUN: counts continuously. The first rising edge of `clk_out` occurs `cur_half` cycles after RUN is entered from parked.
- STOP, or mode 3:
  - If `clk_out`=1, the high half completes normally and the block then parks.
  - If `clk_out`=0, it parks immediately: counter<=0 on the next edge.
  - A low half is never emitted as a runt pulse; `clk_out` is simply held at 0.
- STEP:
  - When parked, `step_req`=1 sets `busy`=1 and counting starts.
  - After `cur_half` cycles, `clk_out` rises and `tick` is 1.
  - After another `cur_half` cycles, `clk_out` falls, `busy` clears and the block parks.
  - `step_req` is ignored while `busy`=1, in any mode other than STEP, and while not parked.
- Leaving RUN for STEP mid-period: behaves as STOP until parked, then waits for `step_req`.
- Changing mode while `busy`=1: the step period always completes. On completion the block enters RUN if `mode`=1, otherwise it parks.
- Simultaneous `step_req` and `div_load` while parked: the new divisor applies to the step's first half.

Test Plan:
- DEFAULT_HALF=4, reset, `mode`=1 -> `clk_out` low for cycles 0-3, rises at cycle 4 with `tick`=1 for one cycle, period 8, `cur_half`=4.
- RUN with `cur_half`=4; pulse `div_load` with `div_half`=2 at counter=1 -> current half still lasts 4 cycles, subsequent halves last 2, `cur_half`=2 from the toggle cycle.
- `div_half`=0 loaded while parked -> `cur_half`=1, RUN gives `clk_out` toggling every cycle (period 2), `tick` every 2 cycles.
- RUN, switch `mode` to 0 one cycle after `clk_out` rises (`cur_half`=4) -> `clk_out` stays high 3 more cycles, falls, stays 0; no further `tick`.
- `mode`=2, parked, `step_req` pulse (`cur_half`=3) -> `busy`=1 next cycle, `clk_out` rises 3 cycles later with `tick`, falls 3 cycles after that, `busy`=0; second `step_req` while `busy` produces no extra period.
- Mid-step, assert `reset_n`=0 for one cycle -> next edge: `clk_out`=0, `busy`=0, `tick`=0, `cur_half`=DEFAULT_HALF; with `mode` held at 2, no activity until a new `step_req`.
